// File: rtl/opb_master_pkg.sv
// Shared types and helpers for the single-beat OPB master: FSM states,
// response codes, bus widths and the little-endian <-> OPB bit-order mapping.
package opb_master_pkg;

  localparam int OPB_AWIDTH  = 32;
  localparam int OPB_DWIDTH  = 32;
  localparam int OPB_BEWIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    RESP = 2'd3
  } opb_state_e;

  typedef enum logic [1:0] {
    RSP_OK         = 2'd0,
    RSP_ERR        = 2'd1,
    RSP_TIMEOUT    = 2'd2,
    RSP_RETRY_FAIL = 2'd3
  } opb_rsp_e;

  // Bit i of the OPB (ascending) vector carries bit W-1-i of the fabric vector.
  function automatic logic [0:OPB_DWIDTH-1] opb_rev_to_bus(input logic [OPB_DWIDTH-1:0] v);
    logic [0:OPB_DWIDTH-1] r;
    for (int i = 0; i < OPB_DWIDTH; i++) r[i] = v[OPB_DWIDTH-1-i];
    return r;
  endfunction

  function automatic logic [OPB_DWIDTH-1:0] opb_rev_from_bus(input logic [0:OPB_DWIDTH-1] v);
    logic [OPB_DWIDTH-1:0] r;
    for (int i = 0; i < OPB_DWIDTH; i++) r[OPB_DWIDTH-1-i] = v[i];
    return r;
  endfunction

  function automatic logic [0:OPB_BEWIDTH-1] opb_rev_be(input logic [OPB_BEWIDTH-1:0] v);
    logic [0:OPB_BEWIDTH-1] r;
    for (int i = 0; i < OPB_BEWIDTH; i++) r[i] = v[OPB_BEWIDTH-1-i];
    return r;
  endfunction

endpackage

// File: rtl/opb_master_tout_cnt.sv
// Transfer watchdog for the OPB master: counts XFER cycles, freezes while
// the slave suppresses timeout, flags expiry in the final counting cycle.
module opb_master_tout_cnt #(
  parameter int C_TOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic hold,
  output logic expired
);

  localparam int CNT_W = $clog2(C_TOUT_CYCLES) + 1;

  logic [CNT_W-1:0] cnt_r;

  // Cycle counter: zero outside XFER, frozen while hold is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (!hold) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Expiry is seen in the C_TOUT_CYCLES-th counted cycle so select drops on its edge.
  assign expired = !clr && !hold && (cnt_r == CNT_W'(C_TOUT_CYCLES - 1));

endmodule

// File: rtl/opb_master_single.sv
// Single-beat OPB bus master: one read or write per command, one response per
// command. Optional transfer watchdog enabled with macro OPB_MASTER_TOUT_EN.
module opb_master_single
  import opb_master_pkg::*;
#(
  parameter int C_OPB_AWIDTH  = OPB_AWIDTH,
  parameter int C_OPB_DWIDTH  = OPB_DWIDTH,
  parameter int C_MAX_RETRY   = 8,
  parameter int C_TOUT_CYCLES = 64
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_rnw,
  input  logic [C_OPB_AWIDTH-1:0] cmd_addr,
  input  logic [3:0]              cmd_be,
  input  logic [C_OPB_DWIDTH-1:0] cmd_data,
  output logic                    rsp_valid,
  output logic [1:0]              rsp_status,
  output logic [C_OPB_DWIDTH-1:0] rsp_data,
  output logic                    M_request,
  input  logic                    OPB_MGrant,
  output logic                    M_select,
  output logic                    M_RNW,
  output logic [0:C_OPB_AWIDTH-1] M_ABus,
  output logic [0:3]              M_BE,
  output logic [0:C_OPB_DWIDTH-1] M_DBus,
  output logic                    M_seqAddr,
  output logic                    M_busLock,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    OPB_xferAck,
  input  logic                    OPB_errAck,
  input  logic                    OPB_retry,
  input  logic                    OPB_toutSup
);

  opb_state_e              state_r, state_next_s;
  opb_rsp_e                status_s;
  logic                    rnw_r;
  logic [C_OPB_AWIDTH-1:0] addr_r;
  logic [3:0]              be_r;
  logic [C_OPB_DWIDTH-1:0] data_r;
  logic [7:0]              retry_cnt_r;
  logic                    retry_inc_s, retry_last_s, tout_exp_s, accept_s;
  logic                    cmd_ready_s, request_s, select_s, rsp_valid_s, rnw_s, capture_s;
  logic [0:C_OPB_AWIDTH-1] abus_s;
  logic [0:3]              be_s;
  logic [0:C_OPB_DWIDTH-1] dbus_s;
  logic [C_OPB_DWIDTH-1:0] rsp_data_s;

  assign accept_s     = (state_r == IDLE) && cmd_valid && cmd_ready;
  assign retry_last_s = ((retry_cnt_r + 8'd1) == 8'(C_MAX_RETRY));
  assign M_seqAddr    = 1'b0;
  assign M_busLock    = 1'b0;

`ifdef OPB_MASTER_TOUT_EN
  opb_master_tout_cnt #(
    .C_TOUT_CYCLES(C_TOUT_CYCLES)
  ) u_tout_cnt (
    .clk    (OPB_Clk),
    .rst_n  (OPB_Rst_n),
    .clr    (state_r != XFER),
    .hold   (OPB_toutSup),
    .expired(tout_exp_s)
  );
`else
  logic unused_tout_s;
  assign tout_exp_s    = 1'b0;
  assign unused_tout_s = OPB_toutSup | (C_TOUT_CYCLES < 1);
`endif

  // State register plus command latch and retry bookkeeping.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state_r     <= IDLE;
      rnw_r       <= 1'b0;
      addr_r      <= {C_OPB_AWIDTH{1'b0}};
      be_r        <= 4'd0;
      data_r      <= {C_OPB_DWIDTH{1'b0}};
      retry_cnt_r <= 8'd0;
    end else begin
      state_r <= state_next_s;
      if (accept_s) begin
        rnw_r       <= cmd_rnw;
        addr_r      <= cmd_addr;
        be_r        <= cmd_be;
        data_r      <= cmd_data;
        retry_cnt_r <= 8'd0;
      end else if (retry_inc_s) begin
        retry_cnt_r <= retry_cnt_r + 8'd1;
      end
    end
  end

  // Next state and response code; exit priority errAck > xferAck > retry > timeout.
  always_comb begin
    state_next_s = state_r;
    status_s     = RSP_OK;
    retry_inc_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) state_next_s = REQ;
        else          state_next_s = IDLE;
      end
      REQ: begin
        if (OPB_MGrant) state_next_s = XFER;
        else            state_next_s = REQ;
      end
      XFER: begin
        if (OPB_errAck) begin
          state_next_s = RESP;
          status_s     = RSP_ERR;
        end else if (OPB_xferAck) begin
          state_next_s = RESP;
          status_s     = RSP_OK;
        end else if (OPB_retry) begin
          retry_inc_s = 1'b1;
          if (retry_last_s) begin
            state_next_s = RESP;
            status_s     = RSP_RETRY_FAIL;
          end else begin
            state_next_s = REQ;
          end
        end else if (tout_exp_s) begin
          state_next_s = RESP;
          status_s     = RSP_TIMEOUT;
        end else begin
          state_next_s = XFER;
        end
      end
      RESP:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Next output values, decoded from the upcoming state so outputs come straight off flops.
  always_comb begin
    cmd_ready_s = (state_next_s == IDLE);
    request_s   = (state_next_s == REQ);
    select_s    = (state_next_s == XFER);
    rsp_valid_s = (state_next_s == RESP);
    capture_s   = (state_r == XFER) && (state_next_s == RESP);
    if (select_s) begin
      rnw_s  = rnw_r;
      abus_s = opb_rev_to_bus(addr_r);
      be_s   = opb_rev_be(be_r);
      if (rnw_r) dbus_s = {C_OPB_DWIDTH{1'b0}};
      else       dbus_s = opb_rev_to_bus(data_r);
    end else begin
      rnw_s  = 1'b0;
      abus_s = {C_OPB_AWIDTH{1'b0}};
      be_s   = 4'd0;
      dbus_s = {C_OPB_DWIDTH{1'b0}};
    end
    if ((status_s == RSP_OK) && rnw_r) rsp_data_s = opb_rev_from_bus(OPB_DBus);
    else                               rsp_data_s = {C_OPB_DWIDTH{1'b0}};
  end

  // Output registers; response fields hold until the next response is captured.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      cmd_ready  <= 1'b0;
      M_request  <= 1'b0;
      M_select   <= 1'b0;
      M_RNW      <= 1'b0;
      M_ABus     <= {C_OPB_AWIDTH{1'b0}};
      M_BE       <= 4'd0;
      M_DBus     <= {C_OPB_DWIDTH{1'b0}};
      rsp_valid  <= 1'b0;
      rsp_status <= 2'd0;
      rsp_data   <= {C_OPB_DWIDTH{1'b0}};
    end else begin
      cmd_ready <= cmd_ready_s;
      M_request <= request_s;
      M_select  <= select_s;
      M_RNW     <= rnw_s;
      M_ABus    <= abus_s;
      M_BE      <= be_s;
      M_DBus    <= dbus_s;
      rsp_valid <= rsp_valid_s;
      if (capture_s) begin
        rsp_status <= status_s;
        rsp_data   <= rsp_data_s;
      end
    end
  end

endmodule

// File: tb/tb_opb_master_single.sv
// Directed bench for opb_master_single: stimulus pushes expected responses
// into a scoreboard queue, a monitor pops and compares on every rsp_valid.
module tb_opb_master_single;

  localparam int MAX_RETRY = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_rnw = 1'b0;
  logic [31:0] cmd_addr = 32'd0, cmd_data = 32'd0;
  logic [3:0]  cmd_be = 4'd0;
  logic        rsp_valid;
  logic [1:0]  rsp_status;
  logic [31:0] rsp_data;
  logic        M_request, M_select, M_RNW, M_seqAddr, M_busLock;
  logic        OPB_MGrant = 1'b0, OPB_xferAck = 1'b0, OPB_errAck = 1'b0;
  logic        OPB_retry = 1'b0, OPB_toutSup = 1'b0;
  logic [0:31] M_ABus, M_DBus;
  logic [0:3]  M_BE;
  logic [0:31] OPB_DBus = 32'd0;

  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [33:0] exp_q[$];

  opb_master_single #(
    .C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32), .C_MAX_RETRY(MAX_RETRY), .C_TOUT_CYCLES(64)
  ) dut (
    .OPB_Clk(clk), .OPB_Rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
    .cmd_addr(cmd_addr), .cmd_be(cmd_be), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_data(rsp_data),
    .M_request(M_request), .OPB_MGrant(OPB_MGrant), .M_select(M_select),
    .M_RNW(M_RNW), .M_ABus(M_ABus), .M_BE(M_BE), .M_DBus(M_DBus),
    .M_seqAddr(M_seqAddr), .M_busLock(M_busLock), .OPB_DBus(OPB_DBus),
    .OPB_xferAck(OPB_xferAck), .OPB_errAck(OPB_errAck), .OPB_retry(OPB_retry),
    .OPB_toutSup(OPB_toutSup)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        check("rsp_status", 32'(rsp_status), 32'(e[33:32]));
        check("rsp_data", rsp_data, e[31:0]);
      end
    end
  end

  task automatic issue(input logic rnw, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] data, output int acc_cyc);
    int t;
    t = 0;
    while (!cmd_ready && t < 50) begin tick(); t++; end
    check("cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_rnw = rnw; cmd_addr = addr; cmd_be = be; cmd_data = data;
    acc_cyc = cyc;
    tick();
    cmd_valid = 1'b0;
  endtask

  // kind 0: xferAck, kind 1: errAck together with xferAck.
  task automatic do_cmd(input logic rnw, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] data, input int gnt_dly, input int waits,
                        input int retries, input int kind, input logic [31:0] rdata,
                        input logic [1:0] exp_st, input logic [31:0] exp_d,
                        output int req_n, output int gaps, output int lat);
    int acc_cyc, t, cur_req, n_try;
    exp_q.push_back({exp_st, exp_d});
    OPB_MGrant = (gnt_dly <= 1);
    issue(rnw, addr, be, data, acc_cyc);
    req_n = 0; gaps = 0;
    n_try = (retries >= MAX_RETRY) ? MAX_RETRY : retries + 1;
    for (int a = 0; a < n_try; a++) begin
      t = 0; cur_req = 0;
      while (!M_select && t < 100) begin
        if (M_request) begin req_n++; cur_req++; end
        OPB_MGrant = (cur_req >= gnt_dly);
        tick(); t++;
      end
      check("sel_seen", 32'(M_select), 32'd1);
      if (gnt_dly > 1) OPB_MGrant = 1'b0;
      check("abus", M_ABus, addr);
      check("be", 32'(M_BE), 32'(be));
      check("dbus", M_DBus, rnw ? 32'd0 : data);
      check("rnw", 32'(M_RNW), 32'(rnw));
      for (int w = 0; w < waits; w++) begin
        check("sel_wait", 32'(M_select), 32'd1);
        tick();
      end
      if (a < retries) begin
        OPB_retry = 1'b1;
        tick();
        OPB_retry = 1'b0;
        check("sel_gap", 32'(M_select), 32'd0);
        gaps++;
      end else begin
        OPB_DBus = rdata; OPB_xferAck = 1'b1; OPB_errAck = (kind == 1);
        tick();
        OPB_DBus = 32'd0; OPB_xferAck = 1'b0; OPB_errAck = 1'b0;
      end
    end
    check("rsp_pulse", 32'(rsp_valid), 32'd1);
    lat = cyc - acc_cyc;
    tick();
    check("rsp_once", 32'(rsp_valid), 32'd0);
    check("status_hold", 32'(rsp_status), 32'(exp_st));
    check("sel_idle", 32'(M_select), 32'd0);
    check("abus_idle", M_ABus, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int req_n, gaps, lat, acc, sel_n;
    tick(); tick();
    check("rst_outs", {24'd0, cmd_ready, rsp_valid, rsp_status, M_request, M_select, M_RNW, M_seqAddr}, 32'd0);
    check("rst_bus", M_ABus | M_DBus | {28'd0, M_BE} | rsp_data, 32'd0);
    rst_n = 1'b1;
    tick();
    check("ready_after_rst", 32'(cmd_ready), 32'd1);

    do_cmd(1'b0, 32'h0100_4200, 4'hF, 32'h1234_5678, 1, 0, 0, 0, 32'd0, 2'd0, 32'd0, req_n, gaps, lat);
    check("wr_latency", 32'(lat), 32'd3);
    check("wr_req_cycles", 32'(req_n), 32'd1);

    do_cmd(1'b1, 32'h0000_0040, 4'hF, 32'hFFFF_FFFF, 5, 2, 0, 0, 32'hDEAD_BEEF, 2'd0, 32'hDEAD_BEEF, req_n, gaps, lat);
    check("rd_req_cycles", 32'(req_n), 32'd5);

    do_cmd(1'b1, 32'h0000_1000, 4'hF, 32'd0, 1, 0, 3, 0, 32'h0000_A5A5, 2'd0, 32'h0000_A5A5, req_n, gaps, lat);
    check("retry3_gaps", 32'(gaps), 32'd3);
    check("retry3_grants", 32'(req_n), 32'd4);

    do_cmd(1'b0, 32'h0000_2000, 4'h3, 32'h5555_AAAA, 1, 0, MAX_RETRY, 0, 32'd0, 2'd3, 32'd0, req_n, gaps, lat);
    check("retryfail_gaps", 32'(gaps), 32'(MAX_RETRY));

    do_cmd(1'b1, 32'h0000_2004, 4'hF, 32'd0, 1, 0, MAX_RETRY - 1, 0, 32'h0BAD_CAFE, 2'd0, 32'h0BAD_CAFE, req_n, gaps, lat);
    check("retry_edge_gaps", 32'(gaps), 32'(MAX_RETRY - 1));

    do_cmd(1'b1, 32'h0000_3000, 4'hF, 32'd0, 1, 1, 0, 1, 32'hCAFE_F00D, 2'd1, 32'd0, req_n, gaps, lat);

    do_cmd(1'b0, 32'h8000_0001, 4'b1000, 32'h8000_0001, 1, 0, 0, 0, 32'd0, 2'd0, 32'd0, req_n, gaps, lat);
    check("bus_order", {29'd0, M_ABus[0], M_BE[0], M_DBus[31]}, 32'd0);

    // Reset in the middle of a write transfer: no response, outputs cleared at once.
    OPB_MGrant = 1'b1;
    issue(1'b0, 32'h0000_4000, 4'hF, 32'hA5A5_5A5A, acc);
    tick();
    check("sel_before_rst", 32'(M_select), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_outs", {24'd0, cmd_ready, rsp_valid, rsp_status, M_request, M_select, M_RNW, M_seqAddr}, 32'd0);
    check("midrst_bus", M_ABus | M_DBus | {28'd0, M_BE} | rsp_data, 32'd0);
    tick(); tick();
    check("rsp_during_rst", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    do_cmd(1'b1, 32'h0000_4000, 4'hF, 32'd0, 1, 0, 0, 0, 32'h1357_9BDF, 2'd0, 32'h1357_9BDF, req_n, gaps, lat);
    check("post_rst_latency", 32'(lat), 32'd3);

`ifdef OPB_MASTER_TOUT_EN
    exp_q.push_back({2'd2, 32'd0});
    OPB_MGrant = 1'b1;
    issue(1'b1, 32'h0000_5000, 4'hF, 32'd0, acc);
    tick();
    sel_n = 0;
    while (M_select && sel_n < 200) begin
      sel_n++;
      OPB_toutSup = (sel_n >= 5 && sel_n <= 14);
      tick();
    end
    OPB_toutSup = 1'b0;
    check("tout_sel_cycles", 32'(sel_n), 32'd74);
    check("tout_pulse", 32'(rsp_valid), 32'd1);
    tick();
`else
    sel_n = 0;
`endif

    tick(); tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'(sel_n * 0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
